// File: rtl/fixed_point_pkg.sv
// -----------------------------------------------------------------------------
// fixed_point_pkg
// Shared types and width helpers for the fixed-point ALU.
//   fp_op_t     : operation select carried through the pipeline
//   fp_max2/3   : constant-width helpers used to size internal formats
//   fp_shr_ext  : fraction extension for the right shift, sized so that every
//                 bit shifted out of the operand is still available for rounding
// -----------------------------------------------------------------------------
package fixed_point_pkg;

  typedef enum logic [1:0] {
    FP_ADD = 2'd0,
    FP_SUB = 2'd1,
    FP_MUL = 2'd2,
    FP_SHR = 2'd3
  } fp_op_t;

  function automatic int fp_max2(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  function automatic int fp_max3(input int x, input int y, input int z);
    return fp_max2(fp_max2(x, y), z);
  endfunction

  function automatic int fp_shr_ext(input int a_w);
    return 1 << $clog2(a_w);
  endfunction

endpackage

// File: rtl/fixed_point_alu_if.sv
// -----------------------------------------------------------------------------
// fixed_point_alu_if
// Operand/result handshake bundle of the fixed-point ALU.
//   master : drives the operand set (in_valid, op, a, b, shamt, round_en,
//            sat_en) and out_ready; observes in_ready and the result side
//   slave  : the ALU itself
// -----------------------------------------------------------------------------
interface fixed_point_alu_if #(
  parameter int A_W  = 26,
  parameter int B_W  = 22,
  parameter int SH_W = 5,
  parameter int O_W  = 26,
  parameter int OI_W = 14
);
  import fixed_point_pkg::*;

  logic            in_valid;
  logic            in_ready;
  fp_op_t          op;
  logic [A_W-1:0]  a;
  logic [B_W-1:0]  b;
  logic [SH_W-1:0] shamt;
  logic            round_en;
  logic            sat_en;
  logic            out_valid;
  logic            out_ready;
  logic [O_W-1:0]  result;
  logic [OI_W-1:0] result_int;
  logic            overflow;

  modport master (
    output in_valid, op, a, b, shamt, round_en, sat_en, out_ready,
    input  in_ready, out_valid, result, result_int, overflow
  );

  modport slave (
    input  in_valid, op, a, b, shamt, round_en, sat_en, out_ready,
    output in_ready, out_valid, result, result_int, overflow
  );

endinterface

// File: rtl/fp_round_sat.sv
// -----------------------------------------------------------------------------
// fp_round_sat
// Output stage: converts a signed Q(IN_INT_W).(IN_FRAC_W) value to
// Q(OUT_INT_W).(OUT_FRAC_W), with optional round-half-up (else floor), range
// check after rounding, and saturate-or-wrap. Result and overflow registered.
//   clk, reset  : clock, synchronous active-high reset
//   en_i        : pipeline advance; output registers hold when low
//   din_i       : intermediate value
//   round_en_i  : 1 = round half up, 0 = truncate toward minus infinity
//   sat_en_i    : 1 = clamp on overflow, 0 = keep low bits
//   result_o    : registered result
//   overflow_o  : registered overflow flag (independent of sat_en_i)
// -----------------------------------------------------------------------------
module fp_round_sat #(
  parameter int IN_INT_W   = 24,
  parameter int IN_FRAC_W  = 44,
  parameter int OUT_INT_W  = 14,
  parameter int OUT_FRAC_W = 12
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   en_i,
  input  logic signed [IN_INT_W+IN_FRAC_W-1:0]   din_i,
  input  logic                                   round_en_i,
  input  logic                                   sat_en_i,
  output logic [OUT_INT_W+OUT_FRAC_W-1:0]        result_o,
  output logic                                   overflow_o
);

  localparam int IN_W = IN_INT_W + IN_FRAC_W;
  localparam int O_W  = OUT_INT_W + OUT_FRAC_W;
  // One spare integer bit so a rounding carry never wraps before the range check.
  localparam int V_W  = IN_INT_W + OUT_FRAC_W + 1;

  logic signed [V_W-1:0] val_s;
  logic                  ovf_s;
  logic [O_W-1:0]        wrap_s;
  logic [O_W-1:0]        res_d;

  generate
    if (IN_FRAC_W > OUT_FRAC_W) begin : g_drop
      localparam int D  = IN_FRAC_W - OUT_FRAC_W;
      localparam int EW = IN_W + 1;
      logic signed [EW-1:0] half_s;
      logic signed [EW-1:0] sum_s;
      // Add half an output LSB when rounding, then floor by arithmetic shift.
      always_comb begin
        half_s = EW'(round_en_i) << (D - 1);
        sum_s  = EW'(din_i) + half_s;
        val_s  = V_W'(sum_s >>> D);
      end
    end else begin : g_fill
      assign val_s = V_W'(din_i) <<< (OUT_FRAC_W - IN_FRAC_W);
    end

    if (V_W > O_W) begin : g_chk
      logic [V_W-O_W:0] top_s;
      // In range only when every bit above the output sign bit matches it.
      assign top_s  = val_s[V_W-1:O_W-1];
      assign ovf_s  = !((&top_s) || !(|top_s));
      assign wrap_s = val_s[O_W-1:0];
    end else begin : g_fit
      assign ovf_s  = 1'b0;
      assign wrap_s = O_W'(val_s);
    end
  endgenerate

  // Select clamp value or wrapped low bits.
  always_comb begin
    res_d = wrap_s;
    if (ovf_s && sat_en_i) begin
      res_d = val_s[V_W-1] ? {1'b1, {(O_W-1){1'b0}}} : {1'b0, {(O_W-1){1'b1}}};
    end else begin
      res_d = wrap_s;
    end
  end

  // Output registers, held while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_o   <= '0;
      overflow_o <= 1'b0;
    end else if (en_i) begin
      result_o   <= res_d;
      overflow_o <= ovf_s;
    end
  end

endmodule

// File: rtl/fixed_point_alu.sv
// -----------------------------------------------------------------------------
// fixed_point_alu
// Three-stage fixed-point ALU (align, compute, round/saturate) with a
// valid/ready handshake. All stages advance together when the output register
// is empty or being consumed, so results leave in input order.
//   clk   : clock
//   reset : synchronous active-high reset, clears all stage valids
//   bus   : operand and result handshake (slave side)
// -----------------------------------------------------------------------------
module fixed_point_alu
  import fixed_point_pkg::*;
#(
  parameter int A_INT_W    = 14,
  parameter int A_FRAC_W   = 12,
  parameter int B_INT_W    = 10,
  parameter int B_FRAC_W   = 12,
  parameter int OUT_INT_W  = 14,
  parameter int OUT_FRAC_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  fixed_point_alu_if.slave bus
);

  localparam int A_W    = A_INT_W + A_FRAC_W;
  localparam int B_W    = B_INT_W + B_FRAC_W;
  localparam int O_W    = OUT_INT_W + OUT_FRAC_W;
  localparam int SH_W   = $clog2(A_W);
  localparam int SH_EXT = fp_shr_ext(A_W);
  // ADD/SUB format: common fraction plus one guard integer bit -> exact sum.
  localparam int ADD_F  = fp_max2(A_FRAC_W, B_FRAC_W);
  localparam int ADD_W  = fp_max2(A_INT_W, B_INT_W) + 1 + ADD_F;
  localparam int MUL_F  = A_FRAC_W + B_FRAC_W;
  localparam int MUL_W  = A_W + B_W;
  localparam int SHR_F  = A_FRAC_W + SH_EXT;
  localparam int SHR_W  = A_W + SH_EXT;
  // Common intermediate format wide enough to hold every operation exactly.
  localparam int II_W   = fp_max3(fp_max2(A_INT_W, B_INT_W) + 1, A_INT_W + B_INT_W, A_INT_W);
  localparam int IF_W   = fp_max3(ADD_F, MUL_F, SHR_F);
  localparam int IW     = II_W + IF_W;

  logic adv_s;

  // Stage 1: aligned operands and sideband
  logic                    v1_q;
  fp_op_t                  op1_q;
  logic                    rnd1_q, sat1_q;
  logic [SH_W-1:0]         sh1_q;
  logic signed [ADD_W-1:0] a_al1_q, b_al1_q, a_al_d, b_al_d;
  logic signed [A_W-1:0]   a1_q;
  logic signed [B_W-1:0]   b1_q;

  // Stage 2: exact intermediate value
  logic                    v2_q;
  logic                    rnd2_q, sat2_q;
  logic signed [IW-1:0]    acc2_q, acc_d;
  logic signed [ADD_W-1:0] sum_s;
  logic signed [MUL_W-1:0] prod_s;
  logic signed [SHR_W-1:0] shr_base_s, shr_s;

  // Stage 3: output register
  logic                    v3_q;
  logic [O_W-1:0]          res_q;
  logic                    ovf_q;

  assign adv_s        = !v3_q || bus.out_ready;
  assign bus.in_ready = adv_s;

  // Align ADD/SUB operands to the common fraction width with sign extension.
  always_comb begin
    a_al_d = ADD_W'($signed(bus.a)) <<< (ADD_F - A_FRAC_W);
    b_al_d = ADD_W'($signed(bus.b)) <<< (ADD_F - B_FRAC_W);
  end

  // Compute every operation exactly and place it in the common format.
  always_comb begin
    sum_s      = (op1_q == FP_SUB) ? (a_al1_q - b_al1_q) : (a_al1_q + b_al1_q);
    prod_s     = MUL_W'(a1_q) * MUL_W'(b1_q);
    // Extend with zero fraction bits so nothing is lost by the shift.
    shr_base_s = {a1_q, {SH_EXT{1'b0}}};
    shr_s      = shr_base_s >>> sh1_q;
    case (op1_q)
      FP_ADD, FP_SUB: acc_d = IW'(sum_s) <<< (IF_W - ADD_F);
      FP_MUL:         acc_d = IW'(prod_s) <<< (IF_W - MUL_F);
      FP_SHR:         acc_d = IW'(shr_s) <<< (IF_W - SHR_F);
      default:        acc_d = '0;
    endcase
  end

  // Stage 1 and stage 2 pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q    <= 1'b0;
      op1_q   <= FP_ADD;
      rnd1_q  <= 1'b0;
      sat1_q  <= 1'b0;
      sh1_q   <= '0;
      a_al1_q <= '0;
      b_al1_q <= '0;
      a1_q    <= '0;
      b1_q    <= '0;
      v2_q    <= 1'b0;
      rnd2_q  <= 1'b0;
      sat2_q  <= 1'b0;
      acc2_q  <= '0;
    end else if (adv_s) begin
      v1_q    <= bus.in_valid;
      op1_q   <= bus.op;
      rnd1_q  <= bus.round_en;
      sat1_q  <= bus.sat_en;
      sh1_q   <= bus.shamt;
      a_al1_q <= a_al_d;
      b_al1_q <= b_al_d;
      a1_q    <= $signed(bus.a);
      b1_q    <= $signed(bus.b);
      v2_q    <= v1_q;
      rnd2_q  <= rnd1_q;
      sat2_q  <= sat1_q;
      acc2_q  <= acc_d;
    end
  end

  // Output valid register.
  always_ff @(posedge clk) begin
    if (reset) begin
      v3_q <= 1'b0;
    end else if (adv_s) begin
      v3_q <= v2_q;
    end
  end

  fp_round_sat #(
    .IN_INT_W  (II_W),
    .IN_FRAC_W (IF_W),
    .OUT_INT_W (OUT_INT_W),
    .OUT_FRAC_W(OUT_FRAC_W)
  ) u_round_sat (
    .clk       (clk),
    .reset     (reset),
    .en_i      (adv_s),
    .din_i     (acc2_q),
    .round_en_i(rnd2_q),
    .sat_en_i  (sat2_q),
    .result_o  (res_q),
    .overflow_o(ovf_q)
  );

  assign bus.out_valid  = v3_q;
  assign bus.result     = res_q;
  assign bus.result_int = res_q[O_W-1:OUT_FRAC_W];
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_fixed_point_alu.sv
// -----------------------------------------------------------------------------
// tb_fixed_point_alu
// Self-checking bench for fixed_point_alu at default widths (A Q14.12,
// B Q10.12, OUT Q14.12). Directed cases plus randomized traffic checked
// against an arithmetic reference model through an in-order scoreboard.
// -----------------------------------------------------------------------------
module tb_fixed_point_alu;
  import fixed_point_pkg::*;

  localparam int A_W  = 26;
  localparam int B_W  = 22;
  localparam int SH_W = 5;
  localparam int O_W  = 26;
  localparam int OI_W = 14;
  localparam int OF   = 12;
  localparam longint MAXV = (longint'(1) <<< (O_W - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (O_W - 1));

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [O_W:0] exp_q[$];

  always #5 clk = ~clk;

  fixed_point_alu_if #(.A_W(A_W), .B_W(B_W), .SH_W(SH_W), .O_W(O_W), .OI_W(OI_W)) bus ();

  fixed_point_alu dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Single comparison point: counts and reports.
  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Exact value of the operation at its natural scale, then converted.
  function automatic logic [O_W:0] ref_model(input fp_op_t op, input logic [A_W-1:0] a,
                                              input logic [B_W-1:0] b, input logic [SH_W-1:0] sh,
                                              input logic rnd, input logic sat);
    longint va, vb, v, q;
    int     fr, d;
    logic   ovf;
    logic [O_W-1:0] r;
    va = longint'($signed(a));
    vb = longint'($signed(b));
    case (op)
      FP_ADD:  begin v = va + vb; fr = 12; end
      FP_SUB:  begin v = va - vb; fr = 12; end
      FP_MUL:  begin v = va * vb; fr = 24; end
      FP_SHR:  begin v = va;      fr = 12 + int'(sh); end
      default: begin v = 0;       fr = 12; end
    endcase
    if (fr > OF) begin
      d = fr - OF;
      if (rnd) v = v + (longint'(1) <<< (d - 1));
      q = v >>> d;
    end else begin
      q = v <<< (OF - fr);
    end
    ovf = (q > MAXV) || (q < MINV);
    if (ovf && sat) q = (q > MAXV) ? MAXV : MINV;
    r = q[O_W-1:0];
    return {ovf, r};
  endfunction

  // One cycle of random traffic; compares outputs and records accepted inputs.
  task automatic step(input logic iv, input logic ordy, output int acc);
    logic [O_W:0] e;
    int sel;
    sel = $urandom_range(7, 0);
    bus.op       = fp_op_t'($urandom_range(3, 0));
    bus.a        = (sel == 0) ? 26'h1FFFFFF : (sel == 1) ? 26'h2000000 : A_W'($urandom);
    bus.b        = (sel == 2) ? 22'h1FFFFF : (sel == 3) ? 22'h200000 : B_W'($urandom);
    bus.shamt    = SH_W'($urandom);
    bus.round_en = 1'($urandom);
    bus.sat_en   = 1'($urandom);
    bus.in_valid = iv;
    bus.out_ready = ordy;
    acc = 0;
    @(negedge clk);
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check_val("sb_unexpected_out", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q[0];
        check_val("sb_result", 64'(bus.result), 64'(e[O_W-1:0]));
        check_val("sb_int", 64'(bus.result_int), 64'(e[O_W-1:OF]));
        check_val("sb_ovf", 64'(bus.overflow), 64'(e[O_W]));
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      exp_q.push_back(ref_model(bus.op, bus.a, bus.b, bus.shamt, bus.round_en, bus.sat_en));
      acc = 1;
    end
    @(posedge clk);
    #1;
  endtask

  // Single directed operation with latency and result checks.
  task automatic do_op(input string tag, input fp_op_t op, input logic [A_W-1:0] a,
                       input logic [B_W-1:0] b, input logic [SH_W-1:0] sh, input logic rnd,
                       input logic sat, input logic [O_W-1:0] er, input logic eo);
    int cnt;
    logic [O_W-1:0] erv;
    erv = er;
    bus.op = op; bus.a = a; bus.b = b; bus.shamt = sh;
    bus.round_en = rnd; bus.sat_en = sat;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #1;
    check_val({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cnt = 0;
    while (!bus.out_valid && cnt < 10) begin
      @(posedge clk); #1;
      cnt++;
    end
    check_val({tag, "_latency"}, 64'(cnt), 64'd2);
    check_val({tag, "_result"}, 64'(bus.result), 64'(erv));
    check_val({tag, "_int"}, 64'(bus.result_int), 64'(erv[O_W-1:OF]));
    check_val({tag, "_ovf"}, 64'(bus.overflow), 64'(eo));
    @(posedge clk); #1;
  endtask

  initial begin
    int acc, acc_total, seen;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = FP_ADD;
    bus.a = '0; bus.b = '0; bus.shamt = '0; bus.round_en = 1'b0; bus.sat_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("rst_result", 64'(bus.result), 64'd0);
    check_val("rst_int", 64'(bus.result_int), 64'd0);
    check_val("rst_ovf", 64'(bus.overflow), 64'd0);
    reset = 1'b0;
    #1;
    check_val("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;

    do_op("add",      FP_ADD, 26'h0003400, 22'h001800, 5'd0, 1'b0, 1'b0, 26'h0004C00, 1'b0);
    do_op("sub",      FP_SUB, 26'h0003400, 22'h001800, 5'd0, 1'b0, 1'b0, 26'h0001C00, 1'b0);
    do_op("mul",      FP_MUL, 26'h0003400, 22'h001800, 5'd0, 1'b0, 1'b0, 26'h0004E00, 1'b0);
    do_op("shr2",     FP_SHR, 26'h0003400, 22'h001800, 5'd2, 1'b0, 1'b0, 26'h0000D00, 1'b0);
    do_op("add_sat",  FP_ADD, 26'h1FFFFFF, 22'h1FF000, 5'd0, 1'b0, 1'b1, 26'h1FFFFFF, 1'b1);
    do_op("add_wrap", FP_ADD, 26'h1FFFFFF, 22'h1FF000, 5'd0, 1'b0, 1'b0, 26'h21FEFFF, 1'b1);
    do_op("shr_trunc", FP_SHR, 26'h3FFFFFF, 22'h000000, 5'd1, 1'b0, 1'b0, 26'h3FFFFFF, 1'b0);
    do_op("shr_round", FP_SHR, 26'h3FFFFFF, 22'h000000, 5'd1, 1'b1, 1'b0, 26'h0000000, 1'b0);
    // Product lies half an LSB below max+1: truncation fits, rounding overflows.
    do_op("mul_trunc", FP_MUL, 26'h1000800, 22'h001FFF, 5'd0, 1'b0, 1'b1, 26'h1FFFFFF, 1'b0);
    do_op("mul_rsat",  FP_MUL, 26'h1000800, 22'h001FFF, 5'd0, 1'b1, 1'b1, 26'h1FFFFFF, 1'b1);
    do_op("mul_rwrap", FP_MUL, 26'h1000800, 22'h001FFF, 5'd0, 1'b1, 1'b0, 26'h2000000, 1'b1);

    // Backpressure: pipeline fills to three entries, then drains in order.
    exp_q.delete();
    acc_total = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, acc);
      acc_total += acc;
    end
    check_val("bp_accepted", 64'(acc_total), 64'd3);
    check_val("bp_in_ready", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, acc);
    check_val("bp_drained", 64'(exp_q.size()), 64'd0);

    // Randomized traffic with random stalls.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(9, 0) < 7), ($urandom_range(9, 0) < 7), acc);
    end
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, acc);
    check_val("rand_drained", 64'(exp_q.size()), 64'd0);

    // Reset with two operations in flight: nothing may emerge afterwards.
    step(1'b1, 1'b1, acc);
    step(1'b1, 1'b1, acc);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    bus.out_ready = 1'b0;
    #1;
    check_val("mid_rst_result", 64'(bus.result), 64'd0);
    check_val("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check_val("mid_rst_flush", 64'(seen), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fixed_point_alu.md
FIXED_POINT_ALU -- requirements
Module: fixed_point_alu

Interface
REQ-001 Parameter A_INT_W, default 14, integer bits of operand A including the sign bit.
REQ-002 Parameter A_FRAC_W, default 12, fraction bits of operand A.
REQ-003 Parameter B_INT_W, default 10, integer bits of operand B including the sign bit.
REQ-004 Parameter B_FRAC_W, default 12, fraction bits of operand B.
REQ-005 Parameter OUT_INT_W, default 14, integer bits of the result including the sign bit.
REQ-006 Parameter OUT_FRAC_W, default 12, fraction bits of the result.
REQ-007 Port clk, input, 1, the only clock; reset is synchronous and active-high.
REQ-008 Port reset, input, 1, synchronous active-high reset.
REQ-009 Port in_valid, input, 1, operand set is presented.
REQ-010 Port in_ready, output, 1, the block accepts the operand set this cycle.
REQ-011 Port op, input, 2, fp_op_t operation: FP_ADD, FP_SUB, FP_MUL or FP_SHR.
REQ-012 Port a, input, A_INT_W+A_FRAC_W, signed two's-complement operand A.
REQ-013 Port b, input, B_INT_W+B_FRAC_W, signed operand B; ignored for FP_SHR.
REQ-014 Port shamt, input, $clog2(A_INT_W+A_FRAC_W), arithmetic right-shift amount for FP_SHR.
REQ-015 Port round_en, input, 1, 1 = round half up, 0 = truncate toward minus infinity.
REQ-016 Port sat_en, input, 1, 1 = saturate on overflow, 0 = wrap.
REQ-017 Port out_valid, output, 1, result is presented.
REQ-018 Port out_ready, input, 1, downstream accepts the result.
REQ-019 Port result, output, OUT_INT_W+OUT_FRAC_W, signed result.
REQ-020 Port result_int, output, OUT_INT_W, integer part of result (result >>> OUT_FRAC_W).
REQ-021 Port overflow, output, 1, exact result lies outside the output range.

Function
REQ-022 Transfer in = in_valid && in_ready; transfer out = out_valid && out_ready.
REQ-023 Three-stage pipeline (align, compute, round/saturate); latency is exactly 3 cycles from input transfer to out_valid when not stalled.
REQ-024 Global advance = !out_valid || out_ready; in_ready = advance; all stages hold when advance is 0.
REQ-025 Sideband inputs (op, round_en, sat_en, shamt) travel with their data; the block never reorders results.
REQ-026 ADD/SUB: operands are sign-extended and aligned to F = max(A_FRAC_W,B_FRAC_W) with one guard integer bit, so the intermediate sum is exact.
REQ-027 MUL: full-precision product of width A_total+B_total with A_FRAC_W+B_FRAC_W fraction bits, computed without loss.
REQ-028 SHR: a >>> shamt, computed with A_FRAC_W+2^$clog2 width fraction extension so the shifted-out bits are kept for rounding.
REQ-029 Output conversion: if intermediate fraction > OUT_FRAC_W, drop bits (round_en=1 adds half an output LSB first); if fraction < OUT_FRAC_W, shift left with zero fill.
REQ-030 Overflow is evaluated after rounding; overflow=1 whenever the value exceeds the output range, independent of sat_en.
REQ-031 sat_en=1 clamps to max (0 followed by all 1s) or min (1 followed by all 0s); sat_en=0 keeps the low OUT_INT_W+OUT_FRAC_W bits.
REQ-032 Rounding that carries a positive value past max is an overflow (REQ-030/031 apply).
REQ-033 result, result_int and overflow are registered and stable while out_valid && !out_ready.

Reset
REQ-034 When reset is high at a clk edge, all stage valids clear: out_valid=0, result=0, result_int=0, overflow=0; in_ready=1 in the cycle after reset.
REQ-035 Reset mid-operation discards in-flight results; none are emitted after reset deasserts.

Structure
REQ-036 Package fixed_point_pkg holds fp_op_t (FP_ADD=0, FP_SUB=1, FP_MUL=2, FP_SHR=3) and the width helper functions.
REQ-037 Sub-module fp_round_sat (parametrised in/out widths, round_en, sat_en, overflow) implements stage 3.

Verification (defaults: A Q14.12, B Q10.12, OUT Q14.12)
REQ-038 a=3.25 (0x3400), b=1.5 (0x1800), FP_ADD -> after 3 cycles result=0x4C00 (4.75), result_int=4, overflow=0.
REQ-039 Same operands, FP_SUB -> 0x1C00 (1.75); FP_MUL -> 0x4E00 (4.875); FP_SHR shamt=2 -> 0x0D00 (0.8125).
REQ-040 a=max (0x1FFFFFF), b=511.0, FP_ADD: sat_en=1 -> result=0x1FFFFFF, overflow=1; sat_en=0 -> wrapped low bits, overflow=1.
REQ-041 Back-to-back ops with out_ready held low for 5 cycles -> in_ready=0 once 3 results are queued, no loss, in-order results after release.
REQ-042 a=-0.000244 (0x3FFFFFF), FP_SHR shamt=1: round_en=0 -> 0x3FFFFFF; round_en=1 -> 0x0000000; reset asserted with 2 ops in flight -> no out_valid afterwards.
